// File: rtl/mem_stall_ctrl.sv
// M-stage data-memory sequencer: turns a load/store into a req/ready handshake,
// stalls the pipeline while the memory is busy and aborts with BusErr on timeout.
module mem_stall_ctrl #(
    parameter int          TIMEOUT  = 255,
    parameter int          CNT_W    = 8,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        StallPipe,
    output logic        MWEn,
    output logic [31:0] ReadDataM,
    output logic        BusErr
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_busErr;
    logic             w_memOp;

    assign w_memOp = MemtoRegM | MemWriteM;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        StallPipe = 1'b0;
        unique case (r_state)
            IDLE: begin
                StallPipe = w_memOp;
                if (w_memOp) begin
                    w_next = REQ;
                end
            end
            REQ: begin
                StallPipe = 1'b1;
                if (mem_ready || (r_count == LAST_WAIT)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // A request is a load exactly when it is not a write (load+store counts as store).
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_count  <= '0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_busErr <= 1'b0;
        end else begin
            r_busErr <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_memOp) begin
                        r_addr  <= ALUOutM;
                        r_wdata <= WriteDataM;
                        r_we    <= MemWriteM;
                        r_req   <= 1'b1;
                        r_count <= '0;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        if (!r_we) begin
                            r_rdata <= mem_rdata;
                        end
                        r_req <= 1'b0;
                    end else if (r_count == LAST_WAIT) begin
                        r_rdata  <= ERR_DATA;
                        r_busErr <= 1'b1;
                        r_req    <= 1'b0;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign ReadDataM = r_rdata;
    assign BusErr    = r_busErr;
    assign MWEn      = ~StallPipe;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Randomized bench for mem_stall_ctrl; each transaction is predicted from its
// ready delay alone (REQ length, stall length, captured data, error pulse).
module tb_mem_stall_ctrl;

    localparam int          TIMEOUT  = 8;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        MemtoRegM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [31:0] ALUOutM = '0;
    logic [31:0] WriteDataM = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        StallPipe;
    logic        MWEn;
    logic [31:0] ReadDataM;
    logic        BusErr;

    int          nVec = 0;
    int          nFail = 0;
    logic [31:0] expRd = '0;

    mem_stall_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (8),
        .ERR_DATA(ERR_DATA)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .MemtoRegM (MemtoRegM),
        .MemWriteM (MemWriteM),
        .ALUOutM   (ALUOutM),
        .WriteDataM(WriteDataM),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .StallPipe (StallPipe),
        .MWEn      (MWEn),
        .ReadDataM (ReadDataM),
        .BusErr    (BusErr)
    );

    always #5 CLK = ~CLK;

    // One transaction issued from IDLE. readyAt is the 1-based REQ cycle that
    // sees mem_ready; anything outside 1..TIMEOUT means the memory never answers.
    task automatic run_txn(input string name, input logic isLoad, input logic isStore,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int readyAt);
        int          reqCycles;
        bit          timedOut;
        logic [31:0] prevRd;
        logic [31:0] wantRd;
        logic        expStall;
        logic        expReq;
        logic        expErr;
        timedOut  = (readyAt < 1) || (readyAt > TIMEOUT);
        reqCycles = timedOut ? TIMEOUT : readyAt;
        prevRd    = expRd;
        wantRd    = prevRd;
        for (int k = 0; k <= reqCycles + 1; k++) begin
            if (k == 0) begin
                MemtoRegM  = isLoad;
                MemWriteM  = isStore;
                ALUOutM    = addr;
                WriteDataM = wdata;
                mem_ready  = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
            end else begin
                MemtoRegM  = 1'($urandom_range(0, 1));
                MemWriteM  = 1'($urandom_range(0, 1));
                ALUOutM    = $urandom;
                WriteDataM = $urandom;
                if (k == readyAt) mem_ready = 1'b1;
                else if (k > reqCycles) mem_ready = 1'($urandom_range(0, 1));
                else mem_ready = 1'b0;
                mem_rdata = (k == readyAt) ? rdata : $urandom;
            end
            @(negedge CLK);
            expStall = (k <= reqCycles);
            expReq   = (k >= 1) && (k <= reqCycles);
            expErr   = timedOut && (k == reqCycles + 1);
            if (k == reqCycles + 1) begin
                if (timedOut) wantRd = ERR_DATA;
                else if (isStore) wantRd = prevRd;
                else wantRd = rdata;
            end
            nVec++;
            if (StallPipe !== expStall) begin
                nFail++;
                $display("[TB] FAIL %s stall k=%0d got %b want %b", name, k, StallPipe, expStall);
            end
            nVec++;
            if (MWEn !== !expStall) begin
                nFail++;
                $display("[TB] FAIL %s mwen k=%0d got %b want %b", name, k, MWEn, !expStall);
            end
            nVec++;
            if (mem_req !== expReq) begin
                nFail++;
                $display("[TB] FAIL %s req k=%0d got %b want %b", name, k, mem_req, expReq);
            end
            nVec++;
            if (BusErr !== expErr) begin
                nFail++;
                $display("[TB] FAIL %s buserr k=%0d got %b want %b", name, k, BusErr, expErr);
            end
            nVec++;
            if (ReadDataM !== wantRd) begin
                nFail++;
                $display("[TB] FAIL %s rdata k=%0d got %h want %h", name, k, ReadDataM, wantRd);
            end
            if (expReq) begin
                nVec++;
                if ({mem_we, mem_addr, mem_wdata} !== {isStore, addr, wdata}) begin
                    nFail++;
                    $display("[TB] FAIL %s reqfields k=%0d got we=%b a=%h d=%h want we=%b a=%h d=%h",
                             name, k, mem_we, mem_addr, mem_wdata, isStore, addr, wdata);
                end
            end
            @(posedge CLK);
            #1;
        end
        expRd = wantRd;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        nVec++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, ReadDataM, BusErr, StallPipe, MWEn} !==
            {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            nFail++;
            $display("[TB] FAIL reset outputs got req=%b we=%b a=%h d=%h rd=%h err=%b st=%b mw=%b want all zero, MWEn=1",
                     mem_req, mem_we, mem_addr, mem_wdata, ReadDataM, BusErr, StallPipe, MWEn);
        end
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        expRd = '0;
    endtask

    task automatic test_load_fast();
        run_txn("load_fast", 1'b1, 1'b0, 32'h100, 32'h0, 32'hCAFE_F00D, 1);
    endtask

    task automatic test_store_wait();
        run_txn("store_wait", 1'b0, 1'b1, 32'h20, 32'h1234_5678, 32'h5555_AAAA, 5);
    endtask

    task automatic test_timeout();
        run_txn("timeout", 1'b1, 1'b0, 32'h300, 32'h0, 32'h1111_2222, 0);
        run_txn("timeout_late", 1'b1, 1'b0, 32'h304, 32'h0, 32'h3333_4444, TIMEOUT + 1);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_load", 1'b1, 1'b0, 32'h40, 32'h0, 32'h0BAD_CAFE, 1);
        run_txn("b2b_store", 1'b0, 1'b1, 32'h44, 32'h7777_8888, 32'h9999_0000, 1);
    endtask

    task automatic test_collision();
        run_txn("collision", 1'b1, 1'b0, 32'h500, 32'h0, 32'hFACE_B00C, TIMEOUT);
    endtask

    task automatic test_both_flags();
        run_txn("both_flags", 1'b1, 1'b1, 32'h600, 32'hABCD_0123, 32'h4242_4242, 2);
    endtask

    task automatic test_ready_idle();
        MemtoRegM = 1'b0;
        MemWriteM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            mem_rdata = $urandom;
            @(negedge CLK);
            nVec++;
            if ({mem_req, StallPipe, MWEn, BusErr, ReadDataM} !== {1'b0, 1'b0, 1'b1, 1'b0, expRd}) begin
                nFail++;
                $display("[TB] FAIL ready_idle i=%0d got req=%b st=%b mw=%b err=%b rd=%h want 0 0 1 0 %h",
                         i, mem_req, StallPipe, MWEn, BusErr, ReadDataM, expRd);
            end
            @(posedge CLK);
            #1;
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        MemtoRegM = 1'b1;
        MemWriteM = 1'b0;
        ALUOutM   = 32'h80;
        mem_ready = 1'b0;
        @(posedge CLK);
        #1;
        MemtoRegM = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        nVec++;
        if (mem_req !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL reset_mid pre req got %b want 1", mem_req);
        end
        #2;
        Reset = 1'b1;
        #1;
        nVec++;
        if ({mem_req, StallPipe, ReadDataM, BusErr} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin
            nFail++;
            $display("[TB] FAIL reset_mid async got req=%b st=%b rd=%h err=%b want 0 0 0 0",
                     mem_req, StallPipe, ReadDataM, BusErr);
        end
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        expRd = '0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 1);
            mem_rdata = $urandom;
            @(negedge CLK);
            nVec++;
            if ({mem_req, StallPipe, ReadDataM, BusErr} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin
                nFail++;
                $display("[TB] FAIL reset_mid post i=%0d got req=%b st=%b rd=%h err=%b want 0 0 0 0",
                         i, mem_req, StallPipe, ReadDataM, BusErr);
            end
            @(posedge CLK);
            #1;
        end
        run_txn("after_reset", 1'b0, 1'b1, 32'h84, 32'h0F0F_0F0F, 32'h0, 2);
    endtask

    task automatic test_random();
        int          op;
        logic        ld;
        logic        st;
        for (int i = 0; i < 24; i++) begin
            op = int'($urandom_range(0, 2));
            ld = (op != 1);
            st = (op != 0);
            run_txn("random", ld, st, $urandom, $urandom, $urandom,
                    int'($urandom_range(0, TIMEOUT + 2)));
        end
    endtask

    initial begin
        test_reset();
        test_load_fast();
        test_store_wait();
        test_timeout();
        test_back_to_back();
        test_collision();
        test_both_flags();
        test_ready_idle();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
